// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with parallel load, wrap/saturate boundary
// handling, an enable prescaler and a registered terminal-count pulse.
module updown_mod_counter #(
   parameter int WIDTH    = 8,
   parameter int TERM_CNT = 255,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             at_max,
   output logic             at_zero
);

   localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [WIDTH-1:0] TERM_V   = WIDTH'(TERM_CNT);
   localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("updown_mod_counter: PRESCALE must be >= 1");
   end
   if ((TERM_CNT < 0) || ((WIDTH < 31) && (TERM_CNT > ((2 ** WIDTH) - 1)))) begin : g_bad_term
      $error("updown_mod_counter: TERM_CNT does not fit in WIDTH bits");
   end

   logic [WIDTH-1:0] count_q, count_d;
   logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
   logic             tc_q, tc_d;
   logic             step_s;

   // Next-state: load beats step, and a step happens only when the prescaler rolls over.
   always_comb begin
      count_d   = count_q;
      pre_cnt_d = pre_cnt_q;
      tc_d      = 1'b0;
      step_s    = 1'b0;
      if (load) begin
         count_d   = (load_val > TERM_V) ? TERM_V : load_val;
         pre_cnt_d = {PW{1'b0}};
      end else if (en) begin
         if (pre_cnt_q == PRE_LAST) begin
            pre_cnt_d = {PW{1'b0}};
            step_s    = 1'b1;
         end else begin
            pre_cnt_d = pre_cnt_q + PW'(1);
         end
      end else begin
         pre_cnt_d = pre_cnt_q;
      end

      // A step at the boundary in the travel direction always flags tc, even when saturating.
      if (step_s) begin
         if (up) begin
            if (count_q == TERM_V) begin
               tc_d    = 1'b1;
               count_d = sat_mode ? count_q : {WIDTH{1'b0}};
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end else begin
            if (count_q == {WIDTH{1'b0}}) begin
               tc_d    = 1'b1;
               count_d = sat_mode ? count_q : TERM_V;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
      end else begin
         tc_d = 1'b0;
      end
   end

   // State registers with synchronous reset; reset also discards any partial prescale.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= {WIDTH{1'b0}};
         pre_cnt_q <= {PW{1'b0}};
         tc_q      <= 1'b0;
      end else begin
         count_q   <= count_d;
         pre_cnt_q <= pre_cnt_d;
         tc_q      <= tc_d;
      end
   end

   assign count   = count_q;
   assign tc      = tc_q;
   assign at_max  = (count_q == TERM_V);
   assign at_zero = (count_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: two counters (PRESCALE 1 and 3, modulus 10) share stimulus;
// a behavioural model queues expected state per edge, compared after the edge.
module tb_updown_mod_counter;

   localparam int TERM = 9;

   logic       clk = 1'b0;
   logic       reset, en, up, sat_mode, load;
   logic [3:0] load_val;
   logic [3:0] cnt_a, cnt_b;
   logic       tc_a, tc_b, max_a, max_b, zero_a, zero_b;

   typedef struct {
      int cnt;
      int pre;
      bit tc;
   } st_t;

   typedef struct {
      st_t a;
      st_t b;
   } exp_t;

   st_t  ma, mb;
   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   updown_mod_counter #(.WIDTH(4), .TERM_CNT(TERM), .PRESCALE(1)) u_a (
      .clk(clk), .reset(reset), .en(en), .up(up), .sat_mode(sat_mode),
      .load(load), .load_val(load_val),
      .count(cnt_a), .tc(tc_a), .at_max(max_a), .at_zero(zero_a)
   );

   updown_mod_counter #(.WIDTH(4), .TERM_CNT(TERM), .PRESCALE(3)) u_b (
      .clk(clk), .reset(reset), .en(en), .up(up), .sat_mode(sat_mode),
      .load(load), .load_val(load_val),
      .count(cnt_b), .tc(tc_b), .at_max(max_b), .at_zero(zero_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Behavioural reference: modular arithmetic for wrap, clamp for saturate.
   function automatic st_t model(input st_t s, input bit rst, input bit ld, input int lv,
                                 input bit e, input bit u, input bit sat, input int presc);
      st_t n;
      bit  stp;
      n    = s;
      n.tc = 1'b0;
      if (rst) begin
         n.cnt = 0;
         n.pre = 0;
      end else if (ld) begin
         n.cnt = (lv > TERM) ? TERM : lv;
         n.pre = 0;
      end else if (e) begin
         stp   = (s.pre + 1 == presc);
         n.pre = stp ? 0 : s.pre + 1;
         if (stp) begin
            n.tc = u ? (s.cnt == TERM) : (s.cnt == 0);
            if (n.tc && sat) n.cnt = s.cnt;
            else if (u)      n.cnt = (s.cnt + 1) % (TERM + 1);
            else             n.cnt = (s.cnt + TERM) % (TERM + 1);
         end
      end
      return n;
   endfunction

   task automatic cyc(input bit rst, input bit ld, input int lv, input bit e,
                      input bit u, input bit sat);
      exp_t x;
      reset = rst; load = ld; load_val = 4'(lv); en = e; up = u; sat_mode = sat;
      ma = model(ma, rst, ld, lv, e, u, sat, 1);
      mb = model(mb, rst, ld, lv, e, u, sat, 3);
      exp_q.push_back('{a: ma, b: mb});
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      check("a_count",  32'(cnt_a),  32'(x.a.cnt));
      check("a_tc",     32'(tc_a),   32'(x.a.tc));
      check("a_at_max", 32'(max_a),  32'(x.a.cnt == TERM));
      check("a_at_zero",32'(zero_a), 32'(x.a.cnt == 0));
      check("b_count",  32'(cnt_b),  32'(x.b.cnt));
      check("b_tc",     32'(tc_b),   32'(x.b.tc));
      check("b_at_max", 32'(max_b),  32'(x.b.cnt == TERM));
      check("b_at_zero",32'(zero_b), 32'(x.b.cnt == 0));
   endtask

   initial begin
      ma = '{cnt: 0, pre: 0, tc: 1'b0};
      mb = '{cnt: 0, pre: 0, tc: 1'b0};
      #2;
      cyc(1, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 1, 0);
      check("rst_count", 32'(cnt_a), 32'd0);
      check("rst_zero",  32'(zero_a), 32'd1);

      // Wrap up: 1..9 then 0 with tc.
      for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 1, 0);
      check("t1_wrap_cnt", 32'(cnt_a), 32'd0);
      check("t1_wrap_tc",  32'(tc_a),  32'd1);
      cyc(0, 0, 0, 1, 1, 0);
      check("t1_tc_drop",  32'(tc_a),  32'd0);

      // Wrap down from reset: 0 -> 9 with tc.
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      check("t2_wrap_cnt", 32'(cnt_a), 32'd9);
      check("t2_wrap_tc",  32'(tc_a),  32'd1);
      for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0, 0);

      // Saturate up from 8, then turn around.
      cyc(0, 1, 8, 0, 1, 1);
      cyc(0, 0, 0, 1, 1, 1);
      check("t3_nine_tc", 32'(tc_a), 32'd0);
      cyc(0, 0, 0, 1, 1, 1);
      check("t3_sat_cnt", 32'(cnt_a), 32'd9);
      check("t3_sat_tc",  32'(tc_a),  32'd1);
      cyc(0, 0, 0, 1, 1, 1);
      check("t3_sat_tc2", 32'(tc_a),  32'd1);
      cyc(0, 0, 0, 1, 0, 1);
      cyc(0, 0, 0, 1, 0, 1);
      check("t3_down", 32'(cnt_a), 32'd7);

      // Load clamp and load-beats-enable.
      cyc(0, 1, 15, 0, 1, 0);
      check("t4_clamp", 32'(cnt_a), 32'd9);
      cyc(0, 1, 3, 1, 1, 0);
      check("t4_ld_en", 32'(cnt_a), 32'd3);

      // Prescaler of 3 holds its phase while en is low.
      cyc(1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 1, 0);
      check("t5_cnt7", 32'(cnt_b), 32'd2);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 1, 0);
      check("t5_hold", 32'(cnt_b), 32'd2);
      cyc(0, 0, 0, 1, 1, 0);
      check("t5_step", 32'(cnt_b), 32'd3);

      // Reset mid-prescale discards the partial count.
      cyc(0, 1, 5, 0, 1, 0);
      cyc(0, 0, 0, 1, 1, 0);
      cyc(1, 0, 0, 1, 1, 0);
      check("t6_rst_cnt", 32'(cnt_b), 32'd0);
      check("t6_rst_tc",  32'(tc_b),  32'd0);
      cyc(0, 0, 0, 1, 1, 0);
      cyc(0, 0, 0, 1, 1, 0);
      check("t6_no_step", 32'(cnt_b), 32'd0);
      cyc(0, 0, 0, 1, 1, 0);
      check("t6_step", 32'(cnt_b), 32'd1);

      // Saturate down at zero: count holds, tc every step.
      cyc(1, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 1, 0, 1);
      cyc(0, 0, 0, 1, 0, 1);
      check("sat0_cnt", 32'(cnt_a), 32'd0);
      check("sat0_tc",  32'(tc_a),  32'd1);

      // Random mix.
      for (int i = 0; i < 200; i++) begin
         cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 7) == 0),
             int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised modulo counter; the next generation of the team's basic up counter.
- Adds up/down direction, parallel load, wrap or saturate mode, an enable prescaler and a terminal-count pulse.
- Used as the timebase and event counter in datapath and memory-test blocks. Cascadable: `tc` of one instance drives `en` of the next.

Parameters:
- WIDTH, 8: counter width in bits.
- TERM_CNT, 255: highest count value (modulus − 1). Must satisfy TERM_CNT ≤ 2**WIDTH − 1. Elaboration error otherwise.
- PRESCALE, 1: number of enabled cycles per count step. Must be ≥ 1. Value 1 means a step on every enabled cycle.

Ports:
- clk  in  1  clock. Rising edge active.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable. Gates the prescaler.
- up  in  1  direction: 1 counts up, 0 counts down. Sampled on each step.
- sat_mode  in  1  boundary mode: 1 saturates (holds at the bound), 0 wraps.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, one cycle wide.
- at_max  out  1  combinational: count == TERM_CNT.
- at_zero  out  1  combinational: count == 0.

Behaviour:
- Reset state: count = 0, tc = 0, internal prescaler pre_cnt = 0.
- Therefore at_zero = 1 after reset. at_max = 1 after reset only if TERM_CNT = 0.
- Priority each rising edge: reset > load > step > hold.
- Load:
  - count <= min(load_val, TERM_CNT), so out-of-range values clamp to TERM_CNT.
  - pre_cnt <= 0 and tc <= 0.
  - Load takes effect regardless of en.
- Prescaler:
  - pre_cnt has width clog2(PRESCALE), minimum 1 bit.
  - When en = 1 and no load: if pre_cnt == PRESCALE − 1, then pre_cnt <= 0 and a step occurs this edge; otherwise pre_cnt increments.
  - When en = 0: pre_cnt and count hold, and tc <= 0.
- Step, up = 1:
  - count < TERM_CNT: count <= count + 1.
  - count == TERM_CNT: wrap mode gives count <= 0; saturate mode holds count.
- Step, up = 0:
  - count > 0: count <= count − 1.
  - count == 0: wrap mode gives count <= TERM_CNT; saturate mode holds count.
- tc:
  - tc <= 1 on any step taken at the boundary in the current direction, in either mode. That is, up at TERM_CNT or down at 0.
  - tc <= 0 on every other edge.
  - In saturate mode, repeated blocked steps produce one tc pulse per step.
- Latency: count and tc update on the same edge as the step, one cycle after the en sample that completes the prescale.
- Changes to up or sat_mode mid-count affect only the next step. No pipeline state is carried.
- Arithmetic is unsigned, modulo TERM_CNT + 1 in wrap mode. count never exceeds TERM_CNT after reset or load.
- Reset asserted mid-prescale discards the partial prescale.
- load and en high together: load wins, and no step occurs that cycle.

Test Plan:
1. WIDTH=4, TERM_CNT=9, PRESCALE=1, up=1, sat_mode=0, en held high after reset → count runs 0,1,…,9,0. tc = 1 exactly in the cycle count shows 0 after 9. at_max = 1 while count = 9.
2. Same configuration, up=0 from reset → count 0,9,8,…,0,9. tc pulses with each 0→9 transition. at_zero = 1 while count = 0.
3. sat_mode=1, up=1, load load_val=8 then enable → count 8,9,9,9. tc = 1 on each cycle after the first 9 (each blocked step). Set up=0 → count 8,7.
4. load_val=15 with TERM_CNT=9 → count = 9 next cycle. Assert load and en together with load_val=3 → count = 3, no increment that cycle.
5. PRESCALE=3, up=1: en high for 7 cycles → count steps on enabled cycles 3 and 6, giving count = 2. Drop en for 2 cycles, then re-raise it → the next step comes after 2 more enabled cycles, since the prescaler held.
6. Assert reset mid-count at count=5 with pre_cnt=1 → next cycle count = 0, tc = 0. Then the first step occurs after a full PRESCALE enabled cycles.
